// File: rtl/dvs_ravens_pkg.sv
// Shared timing constants and types for the DVS to RAVENS event path.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dvs_ravens_pkg;

  // Default timestamp counter width.
  localparam int TIMESTAMP_BITS = 48;
  // Default system clock period in ns.
  localparam int CLK_PERIOD_NS  = 10;
  // Default timestamp LSB resolution in ns (1000 = 1 us).
  localparam int TICK_NS        = 1000;
  // Default number of capture channels.
  localparam int NUM_CAPTURE    = 2;

  typedef logic [TIMESTAMP_BITS-1:0] timestamp_t;

  // Capture channel occupancy; valid is asserted exactly when FULL.
  typedef enum logic {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_e;

  // Clock cycles per timestamp tick. The result is only meaningful when
  // tick_ns is an exact multiple of clk_ns; callers check that separately.
  function automatic int calc_prescale(input int tick_ns, input int clk_ns);
    return tick_ns / clk_ns;
  endfunction

endpackage

// File: rtl/dvs_ts_capture_chan.sv
// Single-entry timestamp capture channel with a sticky overrun flag.
// Latency: trigger to o_valid is 1 cycle.
// Backpressure: o_ts holds while o_valid && !i_ready; triggers arriving then are dropped and flagged.
module dvs_ts_capture_chan
  import dvs_ravens_pkg::*;
#(
  parameter int TS_W = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_trig,
  input  logic            i_ready,
  input  logic            i_clr_overrun,
  input  logic [TS_W-1:0] i_ts,
  output logic            o_valid,
  output logic [TS_W-1:0] o_ts,
  output logic            o_overrun
);

  cap_state_e      r_state;
  logic            r_valid;
  logic [TS_W-1:0] r_ts;
  logic            r_overrun;
  logic            w_lost;

  // A trigger is lost only when the slot is occupied and nobody drains it this cycle.
  assign w_lost = (r_state == CAP_FULL) && i_trig && !i_ready;

  // Occupancy FSM, captured value and overrun flag; a new loss beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CAP_EMPTY;
      r_valid   <= 1'b0;
      r_ts      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_lost | (r_overrun & ~i_clr_overrun);
      case (r_state)
        CAP_EMPTY: begin
          if (i_trig) begin
            r_ts    <= i_ts;
            r_state <= CAP_FULL;
            r_valid <= 1'b1;
          end
        end
        CAP_FULL: begin
          if (i_ready) begin
            if (i_trig) begin
              // Drain and refill in the same cycle keeps full throughput.
              r_ts <= i_ts;
            end else begin
              r_state <= CAP_EMPTY;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= CAP_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid   = r_valid;
  assign o_ts      = r_ts;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/dvs_timestamp_gen.sv
// Free-running prescaled event timestamp with tick/wrap strobes and N capture channels.
// Latency: load and final prescale cycle both visible 1 cycle later; capture valid 1 cycle after trigger.
// Backpressure: per-channel valid/ready; a trigger into a stalled full channel is dropped and flagged.
module dvs_timestamp_gen #(
  parameter int CLK_PERIOD_NS  = dvs_ravens_pkg::CLK_PERIOD_NS,
  parameter int TICK_NS        = dvs_ravens_pkg::TICK_NS,
  parameter int TIMESTAMP_BITS = dvs_ravens_pkg::TIMESTAMP_BITS,
  parameter int NUM_CAPTURE    = dvs_ravens_pkg::NUM_CAPTURE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en_i,
  input  logic                                 load_i,
  input  logic [TIMESTAMP_BITS-1:0]            load_val_i,
  output logic [TIMESTAMP_BITS-1:0]            timestamp_o,
  output logic                                 tick_o,
  output logic                                 wrap_o,
  input  logic [NUM_CAPTURE-1:0]               cap_trig_i,
  output logic [NUM_CAPTURE-1:0]               cap_valid_o,
  input  logic [NUM_CAPTURE-1:0]               cap_ready_i,
  output logic [NUM_CAPTURE*TIMESTAMP_BITS-1:0] cap_ts_o,
  output logic [NUM_CAPTURE-1:0]               cap_overrun_o,
  input  logic [NUM_CAPTURE-1:0]               clr_overrun_i
);

  localparam int PRESCALE = dvs_ravens_pkg::calc_prescale(TICK_NS, CLK_PERIOD_NS);
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  // Reject resolutions that are not a whole number of clock cycles.
  if ((TICK_NS % CLK_PERIOD_NS) != 0 || PRESCALE < 1 || NUM_CAPTURE < 1) begin : g_bad_cfg
    $error("dvs_timestamp_gen: TICK_NS must be a positive multiple of CLK_PERIOD_NS and NUM_CAPTURE >= 1");
  end

  logic [PS_W-1:0]           r_presc;
  logic [TIMESTAMP_BITS-1:0] r_ts;
  logic                      r_tick;
  logic                      r_wrap;
  logic                      w_tick_due;

  // Last prescale cycle of an enabled period: the timestamp advances on this edge.
  assign w_tick_due = en_i && (r_presc == PS_MAX);

  // Prescaler, timestamp counter and registered strobes; load overrides any due tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_ts    <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load_i) begin
      r_presc <= '0;
      r_ts    <= load_val_i;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_tick_due) begin
      r_presc <= '0;
      r_ts    <= r_ts + TIMESTAMP_BITS'(1);
      r_tick  <= 1'b1;
      r_wrap  <= &r_ts;
    end else begin
      if (en_i) begin
        r_presc <= r_presc + PS_W'(1);
      end
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign timestamp_o = r_ts;
  assign tick_o      = r_tick;
  assign wrap_o      = r_wrap;

  // Independent capture channels all sample the currently visible timestamp.
  for (genvar k = 0; k < NUM_CAPTURE; k++) begin : g_cap
    dvs_ts_capture_chan #(
      .TS_W (TIMESTAMP_BITS)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_trig        (cap_trig_i[k]),
      .i_ready       (cap_ready_i[k]),
      .i_clr_overrun (clr_overrun_i[k]),
      .i_ts          (r_ts),
      .o_valid       (cap_valid_o[k]),
      .o_ts          (cap_ts_o[k*TIMESTAMP_BITS +: TIMESTAMP_BITS]),
      .o_overrun     (cap_overrun_o[k])
    );
  end

endmodule

// File: tb/tb_dvs_timestamp_gen.sv
module tb_dvs_timestamp_gen;

  logic        clk;
  logic        rst_n;

  // Default configuration instance (PRESCALE = 100)
  logic        en, load;
  logic [47:0] load_val, ts;
  logic        tick, wrap;
  logic [1:0]  trig, valid, ready, ovr, clr;
  logic [95:0] cap_ts;

  // PRESCALE = 1 instance
  logic        p_en, p_load;
  logic [47:0] p_load_val, p_ts;
  logic        p_tick, p_wrap;
  logic [1:0]  p_trig, p_valid, p_ready, p_ovr, p_clr;
  logic [95:0] p_cap_ts;

  int n_checks = 0;
  int n_fail   = 0;

  dvs_timestamp_gen dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .load_i(load), .load_val_i(load_val),
    .timestamp_o(ts), .tick_o(tick), .wrap_o(wrap),
    .cap_trig_i(trig), .cap_valid_o(valid), .cap_ready_i(ready),
    .cap_ts_o(cap_ts), .cap_overrun_o(ovr), .clr_overrun_i(clr)
  );

  dvs_timestamp_gen #(.CLK_PERIOD_NS(10), .TICK_NS(10)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .en_i(p_en), .load_i(p_load), .load_val_i(p_load_val),
    .timestamp_o(p_ts), .tick_o(p_tick), .wrap_o(p_wrap),
    .cap_trig_i(p_trig), .cap_valid_o(p_valid), .cap_ready_i(p_ready),
    .cap_ts_o(p_cap_ts), .cap_overrun_o(p_ovr), .clr_overrun_i(p_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; load = 1'b0; load_val = '0; trig = '0; ready = '0; clr = '0;
    p_en = 1'b0; p_load = 1'b0; p_load_val = '0; p_trig = '0; p_ready = '0; p_clr = '0;
    cyc(); cyc();
    n_checks++;
    if ({ts, tick, wrap, valid, ovr, cap_ts} !== 150'd0) begin
      n_fail++;
      $display("FAIL reset_main got ts=%h tick=%b wrap=%b valid=%b ovr=%b cap=%h want all zero",
               ts, tick, wrap, valid, ovr, cap_ts);
    end
    n_checks++;
    if ({p_ts, p_tick, p_wrap, p_valid, p_ovr, p_cap_ts} !== 150'd0) begin
      n_fail++;
      $display("FAIL reset_p1 got ts=%h valid=%b cap=%h want all zero", p_ts, p_valid, p_cap_ts);
    end
  endtask

  task automatic test_count();
    int n_tick = 0, n_wrap = 0, bad_pos = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      cyc();
      if (tick) begin
        n_tick++;
        if (i % 100 != 0) bad_pos++;
      end
      if (wrap) n_wrap++;
    end
    n_checks++;
    if (n_tick != 10 || bad_pos != 0) begin
      n_fail++;
      $display("FAIL count_ticks got %0d ticks (%0d misplaced) want 10 at every 100th cycle", n_tick, bad_pos);
    end
    n_checks++;
    if (ts !== 48'd10) begin
      n_fail++;
      $display("FAIL count_ts got %0d want 10", ts);
    end
    n_checks++;
    if (n_wrap != 0) begin
      n_fail++;
      $display("FAIL count_nowrap got %0d wraps want 0", n_wrap);
    end
    // Disabled counter must freeze
    en = 1'b0;
    n_tick = 0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (tick || wrap) n_tick++;
    end
    n_checks++;
    if (ts !== 48'd10 || n_tick != 0) begin
      n_fail++;
      $display("FAIL enable_freeze got ts=%0d strobes=%0d want ts=10 strobes=0", ts, n_tick);
    end
  endtask

  task automatic test_wrap();
    int n_wrap = 0, wrap_cyc = -1, lone_wrap = 0;
    load = 1'b1; load_val = 48'hFFFF_FFFF_FFFF;
    cyc();
    load = 1'b0;
    n_checks++;
    if (ts !== 48'hFFFF_FFFF_FFFF || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL load_disabled got ts=%h tick=%b want ts=ffffffffffff tick=0", ts, tick);
    end
    en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (wrap) begin
        n_wrap++;
        wrap_cyc = i;
        if (!tick) lone_wrap++;
      end
    end
    n_checks++;
    if (n_wrap != 1 || wrap_cyc != 100 || lone_wrap != 0) begin
      n_fail++;
      $display("FAIL wrap_pulse got count=%0d at cycle %0d (no-tick %0d) want 1 at cycle 100 with tick",
               n_wrap, wrap_cyc, lone_wrap);
    end
    n_checks++;
    if (ts !== 48'd0) begin
      n_fail++;
      $display("FAIL wrap_ts got %h want 0", ts);
    end
  endtask

  task automatic test_load_tick_due();
    int early = 0, gap = -1;
    for (int i = 0; i < 99; i++) begin
      cyc();
      if (tick) early++;
    end
    load = 1'b1; load_val = 48'h0000_0000_1234;
    cyc();
    load = 1'b0;
    n_checks++;
    if (tick !== 1'b0 || wrap !== 1'b0 || ts !== 48'h1234 || early != 0) begin
      n_fail++;
      $display("FAIL load_on_tick got tick=%b wrap=%b ts=%h early=%0d want 0 0 1234 0", tick, wrap, ts, early);
    end
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (tick) begin
        gap = i;
        break;
      end
    end
    n_checks++;
    if (gap != 100 || ts !== 48'h1235) begin
      n_fail++;
      $display("FAIL load_next_tick got gap=%0d ts=%h want gap=100 ts=1235", gap, ts);
    end
    en = 1'b0;
  endtask

  task automatic test_cap_overrun();
    load = 1'b1; load_val = 48'd5;
    cyc();
    load = 1'b0;
    trig = 2'b01; ready = 2'b00;
    cyc();
    trig = 2'b00;
    n_checks++;
    if (valid !== 2'b01 || cap_ts[47:0] !== 48'd5 || ovr !== 2'b00) begin
      n_fail++;
      $display("FAIL cap_first got valid=%b ts=%0d ovr=%b want 01 5 00", valid, cap_ts[47:0], ovr);
    end
    load = 1'b1; load_val = 48'd7;
    cyc();
    load = 1'b0;
    trig = 2'b01;
    cyc();
    trig = 2'b00;
    n_checks++;
    if (valid !== 2'b01 || cap_ts[47:0] !== 48'd5 || ovr !== 2'b01) begin
      n_fail++;
      $display("FAIL cap_overrun got valid=%b ts=%0d ovr=%b want 01 5 01", valid, cap_ts[47:0], ovr);
    end
    clr = 2'b01; trig = 2'b01;
    cyc();
    n_checks++;
    if (ovr !== 2'b01 || cap_ts[47:0] !== 48'd5) begin
      n_fail++;
      $display("FAIL clr_vs_overrun got ovr=%b ts=%0d want 01 5", ovr, cap_ts[47:0]);
    end
    trig = 2'b00;
    cyc();
    clr = 2'b00;
    n_checks++;
    if (ovr !== 2'b00 || valid !== 2'b01) begin
      n_fail++;
      $display("FAIL clr_overrun got ovr=%b valid=%b want 00 01", ovr, valid);
    end
    ready = 2'b01;
    cyc();
    ready = 2'b00;
    n_checks++;
    if (valid !== 2'b00) begin
      n_fail++;
      $display("FAIL cap_drain got valid=%b want 00", valid);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    p_en = 1'b1; p_ready = 2'b10; p_trig = 2'b10;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      if (p_valid !== 2'b10 || p_cap_ts[95:48] !== 48'(j - 1) || p_ovr !== 2'b00 || p_tick !== 1'b1) begin
        bad++;
        $display("FAIL b2b_cycle%0d got valid=%b ts=%0d ovr=%b tick=%b want 10 %0d 00 1",
                 j, p_valid, p_cap_ts[95:48], p_ovr, p_tick, j - 1);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    p_trig = 2'b00;
    cyc();
    n_checks++;
    if (p_valid !== 2'b00 || p_ovr !== 2'b00 || p_ts !== 48'd9) begin
      n_fail++;
      $display("FAIL b2b_end got valid=%b ovr=%b ts=%0d want 00 00 9", p_valid, p_ovr, p_ts);
    end
  endtask

  task automatic test_simul_and_reset();
    load = 1'b1; load_val = 48'h42;
    cyc();
    load = 1'b0;
    trig = 2'b11; ready = 2'b00;
    cyc();
    trig = 2'b00;
    n_checks++;
    if (valid !== 2'b11 || cap_ts[47:0] !== 48'h42 || cap_ts[95:48] !== 48'h42) begin
      n_fail++;
      $display("FAIL simul_trig got valid=%b ts0=%h ts1=%h want 11 42 42", valid, cap_ts[47:0], cap_ts[95:48]);
    end
    en = 1'b1; p_trig = 2'b10; p_ready = 2'b00;
    cyc(); cyc();
    p_trig = 2'b00;
    rst_n = 1'b0;
    cyc();
    n_checks++;
    if ({ts, tick, wrap, valid, ovr, cap_ts} !== 150'd0 ||
        {p_ts, p_tick, p_wrap, p_valid, p_ovr, p_cap_ts} !== 150'd0) begin
      n_fail++;
      $display("FAIL reset_midrun got ts=%h valid=%b cap=%h p_ts=%h p_valid=%b want all zero",
               ts, valid, cap_ts, p_ts, p_valid);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_load_tick_due();
    test_cap_overrun();
    test_back_to_back();
    test_simul_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
